// File: rtl/pc_sequencer.sv
// picoMIPS program-counter sequencer: FETCH/EXEC stepping, pc strobe generation,
// input-port handshake and a saturating retired-instruction counter.
module pc_sequencer #(
  parameter int p    = 6,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            dec_jmp,
  input  logic            dec_bra,
  input  logic            dec_beqz,
  input  logic            dec_wait,
  input  logic            dec_halt,
  input  logic            alu_zero,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            ir_load,
  output logic            reg_we,
  output logic            pc_incr,
  output logic            pc_abs,
  output logic            pc_rel,
  output logic            halted,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // p only records the pc width this sequencer is paired with.
  if (p < 1) begin : g_p_invalid
  end

  state_t          state_q, state_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic            retire;

  // Outputs are Mealy so the pc/regfile act on the very next edge; an async
  // reset of state_q therefore drops every strobe immediately.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    in_ready = 1'b0;
    ir_load  = 1'b0;
    reg_we   = 1'b0;
    pc_incr  = 1'b0;
    pc_abs   = 1'b0;
    pc_rel   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_wait) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
          if (dec_jmp)       pc_abs  = 1'b1;
          else if (dec_bra)  pc_rel  = 1'b1;
          else if (dec_beqz) begin
            pc_rel  = alu_zero;
            pc_incr = ~alu_zero;
          end else begin
            pc_incr = 1'b1;
            reg_we  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          reg_we  = 1'b1;
          pc_incr = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    retired_d = (retire && (retired_q != CNT_MAX)) ? retired_q + CNT_ONE : retired_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule
